// File: rtl/decode_control.sv
// Two-phase FETCH/EXECUTE sequencer for the 4-bit accumulator datapath.
// Decodes the fetched opcode and flags into datapath strobes.
module decode_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] instr,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       phase,
  output logic       en_pc,
  output logic       load_pc,
  output logic       en_fetch,
  output logic       en_accu,
  output logic       en_flags,
  output logic       en_out,
  output logic       we_ram,
  output logic       oe_ram,
  output logic       oe_in,
  output logic       oe_oprnd,
  output logic       oe_alu,
  output logic [2:0] alu_sel
);
  typedef enum logic {FETCH = 1'b0, EXECUTE = 1'b1} phase_e;

  typedef struct packed {
    logic       en_pc;
    logic       load_pc;
    logic       en_fetch;
    logic       en_accu;
    logic       en_flags;
    logic       en_out;
    logic       we_ram;
    logic       oe_ram;
    logic       oe_in;
    logic       oe_oprnd;
    logic       oe_alu;
    logic [2:0] alu_sel;
  } strobe_t;

  localparam logic [2:0] ALU_B    = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_NAND = 3'b100;

  phase_e  phase_q, phase_d;
  strobe_t dec, st;
  logic    is_jump, take;

  always_comb begin
    phase_d = phase_q;
    if (enable) phase_d = (phase_q == FETCH) ? EXECUTE : FETCH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_q <= FETCH;
    else        phase_q <= phase_d;
  end

  // EXECUTE decode; two-byte ops that don't jump step the PC past the operand byte.
  always_comb begin
    dec     = '0;
    is_jump = 1'b0;
    take    = 1'b0;
    case (instr)
      4'h0: begin is_jump = 1'b1; take = c_flag;  end
      4'h1: begin is_jump = 1'b1; take = !c_flag; end
      4'h2: begin dec.oe_oprnd = 1'b1; dec.alu_sel = ALU_SUB; dec.en_flags = 1'b1; end
      4'h3: begin dec.oe_ram = 1'b1; dec.alu_sel = ALU_SUB; dec.en_flags = 1'b1; dec.en_pc = 1'b1; end
      4'h4: begin dec.oe_oprnd = 1'b1; dec.alu_sel = ALU_B; dec.en_accu = 1'b1; end
      4'h5: begin dec.oe_in = 1'b1; dec.alu_sel = ALU_B; dec.en_accu = 1'b1; end
      4'h6: begin dec.oe_ram = 1'b1; dec.alu_sel = ALU_B; dec.en_accu = 1'b1; dec.en_pc = 1'b1; end
      4'h7: begin dec.oe_alu = 1'b1; dec.we_ram = 1'b1; dec.en_pc = 1'b1; end
      4'h8: begin is_jump = 1'b1; take = z_flag;  end
      4'h9: begin is_jump = 1'b1; take = !z_flag; end
      4'hA: begin dec.oe_oprnd = 1'b1; dec.alu_sel = ALU_ADD; dec.en_accu = 1'b1; dec.en_flags = 1'b1; end
      4'hB: begin
        dec.oe_ram = 1'b1; dec.alu_sel = ALU_ADD; dec.en_accu = 1'b1;
        dec.en_flags = 1'b1; dec.en_pc = 1'b1;
      end
      4'hC: begin is_jump = 1'b1; take = 1'b1; end
      4'hD: begin dec.oe_alu = 1'b1; dec.en_out = 1'b1; end
      4'hE: begin dec.oe_oprnd = 1'b1; dec.alu_sel = ALU_NAND; dec.en_accu = 1'b1; dec.en_flags = 1'b1; end
      default: begin
        dec.oe_ram = 1'b1; dec.alu_sel = ALU_NAND; dec.en_accu = 1'b1;
        dec.en_flags = 1'b1; dec.en_pc = 1'b1;
      end
    endcase
    if (is_jump) begin
      dec.load_pc = take;
      dec.en_pc   = !take;
    end
  end

  // Reset and stall gate the strobes combinationally so nothing glitches high.
  always_comb begin
    st = '0;
    if (reset && enable) begin
      if (phase_q == FETCH) begin
        st.en_fetch = 1'b1;
        st.en_pc    = 1'b1;
      end else begin
        st = dec;
      end
    end
  end

  assign phase    = phase_q;
  assign en_pc    = st.en_pc;
  assign load_pc  = st.load_pc;
  assign en_fetch = st.en_fetch;
  assign en_accu  = st.en_accu;
  assign en_flags = st.en_flags;
  assign en_out   = st.en_out;
  assign we_ram   = st.we_ram;
  assign oe_ram   = st.oe_ram;
  assign oe_in    = st.oe_in;
  assign oe_oprnd = st.oe_oprnd;
  assign oe_alu   = st.oe_alu;
  assign alu_sel  = st.alu_sel;
endmodule

// File: tb/tb_decode_control.sv
// Directed bench for decode_control: reset, decode table, jumps, stall, abort.
module tb_decode_control;
  logic clk, reset, enable, c_flag, z_flag;
  logic [3:0] instr;
  logic phase, en_pc, load_pc, en_fetch, en_accu, en_flags, en_out;
  logic we_ram, oe_ram, oe_in, oe_oprnd, oe_alu;
  logic [2:0] alu_sel;
  logic [13:0] obs;
  int errors = 0;
  int checks = 0;

  localparam logic [13:0] B_EN_PC    = 14'h2000;
  localparam logic [13:0] B_LOAD_PC  = 14'h1000;
  localparam logic [13:0] B_EN_FETCH = 14'h0800;
  localparam logic [13:0] B_EN_ACCU  = 14'h0400;
  localparam logic [13:0] B_EN_FLAGS = 14'h0200;
  localparam logic [13:0] B_EN_OUT   = 14'h0100;
  localparam logic [13:0] B_WE_RAM   = 14'h0080;
  localparam logic [13:0] B_OE_RAM   = 14'h0040;
  localparam logic [13:0] B_OE_IN    = 14'h0020;
  localparam logic [13:0] B_OE_OPRND = 14'h0010;
  localparam logic [13:0] B_OE_ALU   = 14'h0008;
  localparam logic [13:0] A_B = 14'd1, A_SUB = 14'd2, A_ADD = 14'd3, A_NAND = 14'd4;
  localparam logic [13:0] FETCH_EXP  = B_EN_PC | B_EN_FETCH;

  decode_control dut (
    .clk(clk), .reset(reset), .enable(enable), .instr(instr),
    .c_flag(c_flag), .z_flag(z_flag), .phase(phase),
    .en_pc(en_pc), .load_pc(load_pc), .en_fetch(en_fetch), .en_accu(en_accu),
    .en_flags(en_flags), .en_out(en_out), .we_ram(we_ram), .oe_ram(oe_ram),
    .oe_in(oe_in), .oe_oprnd(oe_oprnd), .oe_alu(oe_alu), .alu_sel(alu_sel)
  );

  assign obs = {en_pc, load_pc, en_fetch, en_accu, en_flags, en_out, we_ram,
                oe_ram, oe_in, oe_oprnd, oe_alu, alu_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the DUT in FETCH, just after a falling edge.
  task automatic restart();
    @(negedge clk); reset = 1'b0; enable = 1'b0;
    @(negedge clk); reset = 1'b1; enable = 1'b1;
    #1;
  endtask

  // From FETCH: present opcode/flags, advance into EXECUTE.
  task automatic run_exec(input logic [3:0] op, input logic c, input logic z);
    instr = op; c_flag = c; z_flag = z;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; instr = 4'h4; c_flag = 1'b0; z_flag = 1'b0;
    #1;
    checks++;
    if (obs !== 14'h0 || phase !== 1'b0) begin
      errors++; $display("FAIL reset_async obs=%h phase=%b want 0000/0", obs, phase);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 14'h0 || phase !== 1'b0) begin
      errors++; $display("FAIL reset_clocked obs=%h phase=%b want 0000/0", obs, phase);
    end
    reset = 1'b1; #1;
    checks++;
    if (obs !== FETCH_EXP || phase !== 1'b0) begin
      errors++; $display("FAIL reset_release obs=%h phase=%b want %h/0", obs, phase, FETCH_EXP);
    end
    @(negedge clk); #1;
    checks++;
    if (phase !== 1'b1 || obs !== (B_OE_OPRND | A_B | B_EN_ACCU)) begin
      errors++; $display("FAIL reset_first_exec obs=%h phase=%b want %h/1", obs, phase,
                         B_OE_OPRND | A_B | B_EN_ACCU);
    end
  endtask

  task automatic test_lit_addi();
    restart();
    run_exec(4'h4, 1'b0, 1'b0);
    checks++;
    if (obs !== (B_OE_OPRND | A_B | B_EN_ACCU) || phase !== 1'b1) begin
      errors++; $display("FAIL lit obs=%h phase=%b want %h/1", obs, phase, B_OE_OPRND | A_B | B_EN_ACCU);
    end
    @(negedge clk); #1;
    run_exec(4'hA, 1'b1, 1'b1);
    checks++;
    if (obs !== (B_OE_OPRND | A_ADD | B_EN_ACCU | B_EN_FLAGS) || phase !== 1'b1) begin
      errors++; $display("FAIL addi obs=%h phase=%b want %h/1", obs, phase,
                         B_OE_OPRND | A_ADD | B_EN_ACCU | B_EN_FLAGS);
    end
  endtask

  task automatic test_cond_jumps();
    // {opcode, c, z, load_pc expected}
    logic [6:0] tab [16] = '{
      {4'h0,1'b0,1'b0,1'b0}, {4'h0,1'b0,1'b1,1'b0}, {4'h0,1'b1,1'b0,1'b1}, {4'h0,1'b1,1'b1,1'b1},
      {4'h1,1'b0,1'b0,1'b1}, {4'h1,1'b0,1'b1,1'b1}, {4'h1,1'b1,1'b0,1'b0}, {4'h1,1'b1,1'b1,1'b0},
      {4'h8,1'b0,1'b0,1'b0}, {4'h8,1'b0,1'b1,1'b1}, {4'h8,1'b1,1'b0,1'b0}, {4'h8,1'b1,1'b1,1'b1},
      {4'h9,1'b0,1'b0,1'b1}, {4'h9,1'b0,1'b1,1'b0}, {4'h9,1'b1,1'b0,1'b1}, {4'h9,1'b1,1'b1,1'b0}};
    logic [13:0] exp;
    restart();
    for (int i = 0; i < 16; i++) begin
      run_exec(tab[i][6:3], tab[i][2], tab[i][1]);
      exp = tab[i][0] ? B_LOAD_PC : B_EN_PC;
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL jump op=%h c=%b z=%b obs=%h want %h",
                           tab[i][6:3], tab[i][2], tab[i][1], obs, exp);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_all_opcodes();
    logic [13:0] tab [16] = '{
      B_EN_PC,
      B_LOAD_PC,
      B_OE_OPRND | A_SUB | B_EN_FLAGS,
      B_OE_RAM | A_SUB | B_EN_FLAGS | B_EN_PC,
      B_OE_OPRND | A_B | B_EN_ACCU,
      B_OE_IN | A_B | B_EN_ACCU,
      B_OE_RAM | A_B | B_EN_ACCU | B_EN_PC,
      B_OE_ALU | B_WE_RAM | B_EN_PC,
      B_EN_PC,
      B_LOAD_PC,
      B_OE_OPRND | A_ADD | B_EN_ACCU | B_EN_FLAGS,
      B_OE_RAM | A_ADD | B_EN_ACCU | B_EN_FLAGS | B_EN_PC,
      B_LOAD_PC,
      B_OE_ALU | B_EN_OUT,
      B_OE_OPRND | A_NAND | B_EN_ACCU | B_EN_FLAGS,
      B_OE_RAM | A_NAND | B_EN_ACCU | B_EN_FLAGS | B_EN_PC};
    logic inv_bad;
    restart();
    for (int i = 0; i < 16; i++) begin
      instr = 4'(i); c_flag = 1'b0; z_flag = 1'b0; #1;
      checks++;
      if (obs !== FETCH_EXP || phase !== 1'b0) begin
        errors++; $display("FAIL fetch op=%h obs=%h phase=%b want %h/0", i, obs, phase, FETCH_EXP);
      end
      @(negedge clk); #1;
      checks++;
      if (obs !== tab[i] || phase !== 1'b1) begin
        errors++; $display("FAIL exec op=%h obs=%h phase=%b want %h/1", i, obs, phase, tab[i]);
      end
      inv_bad = ($countones({oe_ram, oe_in, oe_oprnd, oe_alu}) > 1) ||
                (load_pc && en_pc) || (we_ram && !oe_alu);
      checks++;
      if (inv_bad !== 1'b0) begin
        errors++; $display("FAIL invariant op=%h obs=%h want exclusive strobes", i, obs);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_stall();
    restart();
    run_exec(4'hD, 1'b0, 1'b0);
    checks++;
    if (obs !== (B_OE_ALU | B_EN_OUT)) begin
      errors++; $display("FAIL stall_pre obs=%h want %h", obs, B_OE_ALU | B_EN_OUT);
    end
    enable = 1'b0; #1;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (obs !== 14'h0 || phase !== 1'b1) begin
        errors++; $display("FAIL stall_hold n=%0d obs=%h phase=%b want 0000/1", n, obs, phase);
      end
      @(negedge clk); #1;
    end
    enable = 1'b1; #1;
    checks++;
    if (obs !== (B_OE_ALU | B_EN_OUT) || phase !== 1'b1) begin
      errors++; $display("FAIL stall_resume obs=%h phase=%b want %h/1", obs, phase, B_OE_ALU | B_EN_OUT);
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== FETCH_EXP || phase !== 1'b0) begin
      errors++; $display("FAIL stall_after obs=%h phase=%b want %h/0", obs, phase, FETCH_EXP);
    end
  endtask

  task automatic test_reset_mid_exec();
    restart();
    run_exec(4'hC, 1'b0, 1'b0);
    checks++;
    if (load_pc !== 1'b1) begin
      errors++; $display("FAIL abort_pre load_pc=%b want 1", load_pc);
    end
    #1 reset = 1'b0; #1;
    checks++;
    if (obs !== 14'h0 || phase !== 1'b0) begin
      errors++; $display("FAIL abort_async obs=%h phase=%b want 0000/0", obs, phase);
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== 14'h0 || phase !== 1'b0) begin
      errors++; $display("FAIL abort_hold obs=%h phase=%b want 0000/0", obs, phase);
    end
    reset = 1'b1; #1;
    checks++;
    if (obs !== FETCH_EXP || phase !== 1'b0) begin
      errors++; $display("FAIL abort_restart obs=%h phase=%b want %h/0", obs, phase, FETCH_EXP);
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== B_LOAD_PC || phase !== 1'b1) begin
      errors++; $display("FAIL abort_reexec obs=%h phase=%b want %h/1", obs, phase, B_LOAD_PC);
    end
  endtask

  initial begin
    test_reset();
    test_lit_addi();
    test_cond_jumps();
    test_all_opcodes();
    test_stall();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
